sram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single shared instruction/data SRAM. It lets the program loader (port 0) and the GPP fetch/load path (port 1) share one SRAM port. It grants requests round-robin, drives the SRAM control signals (Addr, RW, En, write data) and returns registered read data with a valid pulse. It sits between the GPP core, the loader and the SRAM model, replacing direct core-to-SRAM wiring.

---
 rtl/sram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one SRAM port between
// the program loader (port 0) and the GPP fetch/load path (port 1).
module sram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          R0Req,
    input  logic          R0RW,
    input  logic [AW-1:0] R0Addr,
    input  logic [DW-1:0] R0WData,
    output logic          R0Gnt,
    output logic          R0RVld,
    output logic [DW-1:0] R0RData,
    input  logic          R1Req,
    input  logic          R1RW,
    input  logic [AW-1:0] R1Addr,
    input  logic [DW-1:0] R1WData,
    output logic          R1Gnt,
    output logic          R1RVld,
    output logic [DW-1:0] R1RData,
    output logic [AW-1:0] Addr,
    output logic [DW-1:0] WData,
    output logic          RW,
    output logic          En,
    input  logic [DW-1:0] Data,
    output logic          Busy,
    output logic [1:0]    DbgState
);

    // Handshake: a port holds Req (and its fields) high until it sees a
    // one-cycle Gnt; a read then returns one RVld pulse with RData updated.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic          pick;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          en_q, en_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvld0_q, rvld0_d, rvld1_q, rvld1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rw_d     = rw_q;
        en_d     = 1'b0;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        rvld0_d  = 1'b0;
        rvld1_d  = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // Under contention the port that did not win last time goes first.
        pick     = (R0Req && R1Req) ? ~last_q : R1Req;

        case (state_q)
            IDLE: begin
                if (R0Req || R1Req) begin
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = pick ? R1Addr  : R0Addr;
                    wdata_d = pick ? R1WData : R0WData;
                    rw_d    = pick ? R1RW    : R0RW;
                    en_d    = 1'b1;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = rw_q ? IDLE : WAIT;
            WAIT: begin
                state_d = RESP;
                if (win_q) begin
                    rdata1_d = Data;
                    rvld1_d  = 1'b1;
                end else begin
                    rdata0_d = Data;
                    rvld0_d  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rvld0_q  <= 1'b0;
            rvld1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            rvld0_q  <= rvld0_d;
            rvld1_q  <= rvld1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign R0Gnt    = gnt0_q;
    assign R1Gnt    = gnt1_q;
    assign R0RVld   = rvld0_q;
    assign R1RVld   = rvld1_q;
    assign R0RData  = rdata0_q;
    assign R1RData  = rdata1_q;
    assign Addr     = addr_q;
    assign WData    = wdata_q;
    assign RW       = rw_q;
    assign En       = en_q;
    assign Busy     = busy_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a registered-read SRAM model.
module tb_sram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          R0Req, R0RW, R1Req, R1RW;
  logic [AW-1:0] R0Addr, R1Addr;
  logic [DW-1:0] R0WData, R1WData;
  logic          R0Gnt, R0RVld, R1Gnt, R1RVld;
  logic [DW-1:0] R0RData, R1RData;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WData;
  logic          RW, En, Busy;
  logic [DW-1:0] Data;
  logic [1:0]    DbgState;

  logic [DW-1:0] mem [0:255];
  logic          mem_init;
  int            vectors = 0;
  int            miscompares = 0;
  int            en_cnt = 0, g0_cnt = 0, g1_cnt = 0, excl_err = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .R0Req(R0Req), .R0RW(R0RW), .R0Addr(R0Addr), .R0WData(R0WData),
    .R0Gnt(R0Gnt), .R0RVld(R0RVld), .R0RData(R0RData),
    .R1Req(R1Req), .R1RW(R1RW), .R1Addr(R1Addr), .R1WData(R1WData),
    .R1Gnt(R1Gnt), .R1RVld(R1RVld), .R1RData(R1RData),
    .Addr(Addr), .WData(WData), .RW(RW), .En(En), .Data(Data),
    .Busy(Busy), .DbgState(DbgState)
  );

  // SRAM model: write commits at the En edge, read data appears one edge later
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[1] <= 32'h1111_0001;
      mem[2] <= 32'h2222_0002;
      mem[3] <= 32'h3333_0003;
      mem[4] <= 32'h4444_0004;
      mem[5] <= 32'h0000_1234;
    end else if (En) begin
      if (RW) mem[Addr] <= WData;
      else    Data <= mem[Addr];
    end
  end

  // activity monitor
  always @(negedge Clk) begin
    if (En === 1'b1)    en_cnt++;
    if (R0Gnt === 1'b1) g0_cnt++;
    if (R1Gnt === 1'b1) g1_cnt++;
    if ((R0Gnt & R1Gnt) | (R0RVld & R1RVld) | (En !== (R0Gnt | R1Gnt)))
      excl_err++;
  end

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    Rst = 1'b1; mem_init = 1'b1; Data = '0;
    R0Req = 0; R0RW = 0; R0Addr = '0; R0WData = '0;
    R1Req = 0; R1RW = 0; R1Addr = '0; R1WData = '0;
    tick; tick;
    mem_init = 1'b0;
    // reset state
    chk("rst_en", En, 0);        chk("rst_busy", Busy, 0);
    chk("rst_addr", Addr, 0);    chk("rst_wdata", WData, 0);
    chk("rst_rw", RW, 0);        chk("rst_gnt", {R0Gnt, R1Gnt}, 0);
    chk("rst_rvld", {R0RVld, R1RVld}, 0);
    chk("rst_rd0", R0RData, 0);  chk("rst_rd1", R1RData, 0);
    chk("rst_state", DbgState, 0);
    Rst = 1'b0;
    tick;
    chk("idle_busy", Busy, 0);

    // single port 1 read of Addr 5
    R1Req = 1; R1RW = 0; R1Addr = 8'd5;
    tick;
    chk("t1_gnt1", R1Gnt, 1);  chk("t1_gnt0", R0Gnt, 0);
    chk("t1_en", En, 1);       chk("t1_rw", RW, 0);
    chk("t1_addr", Addr, 5);   chk("t1_busy", Busy, 1);
    chk("t1_state", DbgState, 1);
    R1Req = 0;
    tick;
    chk("t1_wait_en", En, 0);  chk("t1_wait_gnt", R1Gnt, 0);
    chk("t1_wait_rvld", R1RVld, 0);
    tick;
    chk("t1_rvld", R1RVld, 1); chk("t1_rdata", R1RData, 32'h0000_1234);
    chk("t1_rvld0", R0RVld, 0);
    tick;
    chk("t1_done_busy", Busy, 0); chk("t1_done_rvld", R1RVld, 0);
    chk("t1_hold", R1RData, 32'h0000_1234);

    // simultaneous reads: port 0 first, then port 1
    R0Req = 1; R0RW = 0; R0Addr = 8'd1;
    R1Req = 1; R1RW = 0; R1Addr = 8'd2;
    tick;
    chk("t2_gnt0", R0Gnt, 1);  chk("t2_gnt1", R1Gnt, 0);
    chk("t2_addr", Addr, 1);
    R0Req = 0;
    tick; tick;
    chk("t2_rvld0", R0RVld, 1); chk("t2_rd0", R0RData, 32'h1111_0001);
    chk("t2_rd1_keep", R1RData, 32'h0000_1234);
    tick;
    chk("t2_idle_gnt1", R1Gnt, 0);
    tick;
    chk("t2_gnt1b", R1Gnt, 1); chk("t2_addr2", Addr, 2);
    R1Req = 0;
    tick; tick;
    chk("t2_rvld1", R1RVld, 1); chk("t2_rd1", R1RData, 32'h2222_0002);
    chk("t2_rd0_keep", R0RData, 32'h1111_0001);
    tick;

    // port 0 write then port 1 read back
    R0Req = 1; R0RW = 1; R0Addr = 8'd7; R0WData = 32'hDEAD_BEEF;
    tick;
    chk("t3_gnt0", R0Gnt, 1);  chk("t3_en", En, 1); chk("t3_rw", RW, 1);
    chk("t3_addr", Addr, 7);   chk("t3_wdata", WData, 32'hDEAD_BEEF);
    R0Req = 0; R0WData = 32'h0BAD_0BAD;
    tick;
    chk("t3_en_off", En, 0);   chk("t3_busy", Busy, 0);
    chk("t3_wdata_keep", WData, 32'hDEAD_BEEF);
    chk("t3_mem7", mem[7], 32'hDEAD_BEEF);
    R1Req = 1; R1RW = 0; R1Addr = 8'd7;
    tick;
    chk("t3_gnt1", R1Gnt, 1);  chk("t3_rd_rw", RW, 0);
    R1Req = 0;
    tick; tick;
    chk("t3_rd1", R1RData, 32'hDEAD_BEEF);
    tick;

    // port 1 back-to-back reads, port 0 cuts in mid-stream
    R1Req = 1; R1RW = 0; R1Addr = 8'd1;
    tick;
    chk("t4_g1", R1Gnt, 1);
    R1Addr = 8'd2;
    tick; tick;
    chk("t4_rd_a", R1RData, 32'h1111_0001);
    tick;
    chk("t4_gap", R1Gnt, 0);
    tick;
    chk("t4_g2", R1Gnt, 1);    chk("t4_g2_addr", Addr, 2);
    R1Addr = 8'd3;
    R0Req = 1; R0RW = 0; R0Addr = 8'd5;
    tick;
    chk("t4_held0", R0Gnt, 0);
    tick;
    chk("t4_rd_b", R1RData, 32'h2222_0002);
    tick;
    tick;
    chk("t4_g0", R0Gnt, 1);    chk("t4_g0_not1", R1Gnt, 0);
    chk("t4_g0_addr", Addr, 5);
    R0Req = 0;
    tick; tick;
    chk("t4_rd0", R0RData, 32'h0000_1234);
    tick; tick;
    chk("t4_g3", R1Gnt, 1);    chk("t4_g3_addr", Addr, 3);
    R1Req = 0;
    tick; tick;
    chk("t4_rd_c", R1RData, 32'h3333_0003);
    tick;

    // reset during WAIT of a port 0 read
    R0Req = 1; R0RW = 0; R0Addr = 8'd2;
    tick;
    chk("t5_gnt0", R0Gnt, 1);
    R0Req = 0;
    tick;
    chk("t5_wait", DbgState, 2);
    Rst = 1;
    tick;
    chk("t5_rvld0", R0RVld, 0); chk("t5_rd0", R0RData, 0);
    chk("t5_rd1", R1RData, 0);  chk("t5_busy", Busy, 0);
    chk("t5_addr", Addr, 0);    chk("t5_en", En, 0);
    chk("t5_state", DbgState, 0);
    Rst = 0;
    tick;
    chk("t5_no_rvld", R0RVld, 0);
    R0Req = 1; R0RW = 0; R0Addr = 8'd1;
    R1Req = 1; R1RW = 0; R1Addr = 8'd3;
    tick;
    chk("t5_last_rst", R0Gnt, 1);
    R0Req = 0;
    tick; tick;
    chk("t5_rd0_new", R0RData, 32'h1111_0001);
    tick; tick;
    chk("t5_gnt1", R1Gnt, 1);
    R1Req = 0;
    tick; tick;
    chk("t5_rd1_new", R1RData, 32'h3333_0003);
    tick;

    // short-lived port 0 request while busy is dropped
    R1Req = 1; R1RW = 0; R1Addr = 8'd4;
    tick;
    R1Req = 0;
    R0Req = 1; R0RW = 1; R0Addr = 8'd6; R0WData = 32'h6666_6666;
    tick;
    R0Req = 0;
    tick;
    chk("t6_rd1", R1RData, 32'h4444_0004);
    tick; tick; tick;
    chk("t6_busy", Busy, 0);
    chk("t6_mem6", mem[6], 0);

    @(posedge Clk);
    chk("en_pulses", en_cnt, 13);
    chk("r0_grants", g0_cnt, 5);
    chk("r1_grants", g1_cnt, 8);
    chk("exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
